moving_avg_sched: RTL and testbench

- Multi-channel moving-average engine. One shared add/subtract datapath is time-shared by CHANNELS requesters through a round-robin arbiter.
- Each channel keeps its own window history, running sum, write pointer and fill count.
- Sits between per-channel sample sources (e.g. ADC/demod lanes) and a single downstream sink, replacing N separate moving_avg instances.

---
 rtl/moving_avg_sched_if.sv | 29 ++
 rtl/moving_avg_sched.sv | 181 ++++++++++++++++++
 tb/tb_moving_avg_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/moving_avg_sched_if.sv
// Handshake bundle between per-channel sample sources, the shared
// moving-average engine and the single downstream result sink.
interface moving_avg_sched_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [CW-1:0]                  out_chan;
  logic                           out_full;
  logic                           out_valid;
  logic                           out_ready;

  // Source/sink side of the bundle.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_data, out_chan, out_full, out_valid
  );

  // Engine side of the bundle.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_data, out_chan, out_full, out_valid
  );
endinterface

// File: rtl/moving_avg_sched.sv
// Multi-channel moving-average engine. A single add/subtract datapath is
// shared round-robin between CHANNELS sample sources; every channel owns its
// window history, running sum, write pointer and fill count.
//
// state  | meaning
// IDLE   | flush or arbitrate; in_ready pulses to the granted channel
// READ   | fetch the history entry about to be overwritten
// UPDATE | sum += new - old, write history, advance pointer/fill, latch result
// OUT    | present the result until the sink takes it
module moving_avg_sched #(
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WINDOW_SHIFT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  output logic              busy,
  moving_avg_sched_if.slave bus
);

  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int WINDOW = 1 << WINDOW_SHIFT;
  localparam int SW     = DATA_WIDTH + WINDOW_SHIFT;
  localparam int FW     = WINDOW_SHIFT + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           grant_q;
  logic [CW-1:0]           last_q;
  logic [CW-1:0]           grant_d;
  logic [CW-1:0]           idx_c;
  logic                    req_found;
  logic                    take;
  logic [CHANNELS-1:0]     in_ready_d;

  logic [DATA_WIDTH-1:0]   new_q;
  logic [DATA_WIDTH-1:0]   old_q;
  logic [DATA_WIDTH-1:0]   hist_q [CHANNELS][WINDOW];
  logic [SW-1:0]           sum_q  [CHANNELS];
  logic [WINDOW_SHIFT-1:0] ptr_q  [CHANNELS];
  logic [FW-1:0]           fill_q [CHANNELS];

  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CW-1:0]           out_chan_q;
  logic                    out_full_q;

  logic [DATA_WIDTH-1:0]   in_data_a [CHANNELS];
  logic [SW-1:0]           sum_new;
  logic [FW-1:0]           fill_new;
  logic [DATA_WIDTH-1:0]   avg_new;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign in_data_a[c] = bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first requester after the last grant, wrapping.
  always_comb begin
    grant_d   = last_q;
    req_found = 1'b0;
    idx_c     = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx_c = CW'((int'(last_q) + i) % CHANNELS);
      if (!req_found && bus.in_valid[idx_c]) begin
        req_found = 1'b1;
        grant_d   = idx_c;
      end
    end
  end

  // A grant is only issued from IDLE and only when no flush is pending.
  assign take = (state_q == IDLE) && !flush && req_found;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and the one-hot accept pulse.
  always_comb begin
    state_d    = state_q;
    in_ready_d = '0;
    case (state_q)
      IDLE: begin
        if (take) begin
          in_ready_d[grant_d] = 1'b1;
          state_d             = READ;
        end
      end
      READ:    state_d = UPDATE;
      UPDATE:  state_d = OUT;
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared datapath: the old entry is already in old_q, so the running sum
  // can never underflow and never exceeds WINDOW * max sample.
  always_comb begin
    sum_new  = sum_q[grant_q] + SW'(new_q) - SW'(old_q);
    fill_new = (fill_q[grant_q] == FW'(WINDOW)) ? fill_q[grant_q]
                                                : fill_q[grant_q] + FW'(1);
    avg_new  = DATA_WIDTH'(sum_new >> WINDOW_SHIFT);
  end

  // Per-channel state, captured sample and registered result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_q    <= '0;
      last_q     <= CW'(CHANNELS - 1);
      new_q      <= '0;
      old_q      <= '0;
      out_data_q <= '0;
      out_chan_q <= '0;
      out_full_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
        for (int w = 0; w < WINDOW; w++) begin
          hist_q[c][w] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            for (int c = 0; c < CHANNELS; c++) begin
              sum_q[c]  <= '0;
              ptr_q[c]  <= '0;
              fill_q[c] <= '0;
              for (int w = 0; w < WINDOW; w++) begin
                hist_q[c][w] <= '0;
              end
            end
          end else if (take) begin
            grant_q <= grant_d;
            last_q  <= grant_d;
            new_q   <= in_data_a[grant_d];
          end
        end
        READ: begin
          old_q <= hist_q[grant_q][ptr_q[grant_q]];
        end
        UPDATE: begin
          sum_q[grant_q]                 <= sum_new;
          hist_q[grant_q][ptr_q[grant_q]] <= new_q;
          ptr_q[grant_q]                 <= ptr_q[grant_q] + WINDOW_SHIFT'(1);
          fill_q[grant_q]                <= fill_new;
          out_data_q                     <= avg_new;
          out_chan_q                     <= grant_q;
          out_full_q                     <= (fill_new == FW'(WINDOW));
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_full  = out_full_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_moving_avg_sched.sv
// Directed bench for the multi-channel moving-average engine.
module tb_moving_avg_sched;

  logic clock;
  logic reset;
  logic flush;
  logic busy;

  int n_cmp;
  int n_err;

  logic [15:0] d3 [4];

  moving_avg_sched_if #(.CHANNELS(4), .DATA_WIDTH(16)) bus ();

  moving_avg_sched #(
    .CHANNELS(4), .DATA_WIDTH(16), .WINDOW_SHIFT(3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request one sample on ch and check the grant, latency and result.
  task automatic xact(input int ch, input logic [15:0] d, input logic [15:0] ea,
                      input logic ef, input logic fl_read);
    int   n;
    logic got;
    logic ov1, ov2, ov3;
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*16 +: 16] = d;
    #1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      if (bus.in_ready[ch]) got = 1'b1;
      else begin
        @(negedge clock); #1;
        n++;
      end
    end
    chk("grant", 32'(got), 32'd1);
    chk("in_ready_onehot", 32'(bus.in_ready), 32'(1) << ch);
    @(negedge clock);
    bus.in_valid[ch] = 1'b0;
    flush = fl_read;
    ov1 = bus.out_valid;
    @(negedge clock);
    flush = 1'b0;
    ov2 = bus.out_valid;
    @(negedge clock);
    ov3 = bus.out_valid;
    chk("latency", 32'({ov1, ov2, ov3}), 32'b001);
    chk("out_data", 32'(bus.out_data), 32'(ea));
    chk("out_chan", 32'(bus.out_chan), 32'(ch));
    chk("out_full", 32'(bus.out_full), 32'(ef));
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    d3[0] = 16'd16;
    d3[1] = 16'd800;
    d3[2] = 16'hFFFF;
    d3[3] = 16'h1000;
    reset = 1'b0;
    flush = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_state", 32'({bus.out_valid, busy, bus.in_ready, bus.out_chan,
                            bus.out_full, bus.out_data}), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // ch0: constant 8 -> averages 1..8, full only on the eighth
    for (int k = 1; k <= 8; k++) begin
      xact(0, 16'd8, 16'(k), (k == 8), 1'b0);
    end

    // ch1: ramp 1..16, pointer wraps past entry 7
    for (int k = 1; k <= 16; k++) begin
      xact(1, 16'(k), (k <= 8) ? 16'((k * (k + 1) / 2) / 8) : 16'(k - 4),
           (k >= 8), 1'b0);
    end

    // reset pulse in IDLE restores channel 0 priority and clears outputs
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_mid", 32'({bus.out_valid, busy, bus.in_ready, bus.out_chan,
                          bus.out_full, bus.out_data}), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // all four channels requesting continuously: round-robin 0,1,2,3,...
    for (int c = 0; c < 4; c++) bus.in_data[c*16 +: 16] = d3[c];
    bus.in_valid = 4'b1111;
    #1;
    for (int i = 0; i < 32; i++) begin
      n = 0;
      while (bus.in_ready == 4'b0000 && n < 10) begin
        @(negedge clock); #1;
        n++;
      end
      chk("rr_grant", 32'(bus.in_ready), 32'(1) << (i % 4));
      repeat (3) @(negedge clock);
      chk("rr_valid", 32'(bus.out_valid), 32'd1);
      chk("rr_chan", 32'(bus.out_chan), 32'(i % 4));
      chk("rr_data", 32'(bus.out_data), (32'(d3[i % 4]) * 32'(i / 4 + 1)) >> 3);
      chk("rr_full", 32'(bus.out_full), 32'((i / 4) == 7));
    end
    bus.in_valid = 4'b0000;

    // sink back-pressure: result held, no grants, busy stays high
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid[0] = 1'b1;
    bus.in_data[0 +: 16] = 16'd48;
    bus.in_valid[1] = 1'b1;
    bus.in_data[16 +: 16] = 16'd800;
    #1;
    chk("stall_grant", 32'(bus.in_ready), 32'b0001);
    @(negedge clock);
    bus.in_valid[0] = 1'b0;
    repeat (2) @(negedge clock);
    for (int j = 0; j < 5; j++) begin
      chk("stall_hold", 32'({bus.out_valid, busy, bus.in_ready, bus.out_chan,
                             bus.out_full, bus.out_data}),
          32'({1'b1, 1'b1, 4'b0000, 2'd0, 1'b1, 16'd20}));
      if (j < 4) @(negedge clock);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("stall_resume", 32'(bus.in_ready), 32'b0010);
    @(negedge clock);
    bus.in_valid[1] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("stall_next", 32'({bus.out_valid, bus.out_chan, bus.out_full, bus.out_data}),
        32'({1'b1, 2'd1, 1'b1, 16'd800}));

    // ch3 full of 0x1000: three samples of 80 slide into the window
    xact(3, 16'd80, 16'd3594, 1'b1, 1'b0);
    xact(3, 16'd80, 16'd3092, 1'b1, 1'b0);
    xact(3, 16'd80, 16'd2590, 1'b1, 1'b0);
    @(negedge clock);
    flush = 1'b1;
    bus.in_valid[3] = 1'b1;
    bus.in_data[48 +: 16] = 16'd80;
    #1;
    chk("flush_prio", 32'({bus.in_ready, busy}), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    xact(3, 16'd80, 16'd10, 1'b0, 1'b0);
    xact(3, 16'd80, 16'd20, 1'b0, 1'b1);
    xact(3, 16'd80, 16'd30, 1'b0, 1'b0);

    // reset during UPDATE abandons the operation
    @(negedge clock);
    bus.in_valid[1] = 1'b1;
    bus.in_data[16 +: 16] = 16'd800;
    #1;
    chk("pre_reset_grant", 32'(bus.in_ready), 32'b0010);
    @(negedge clock);
    bus.in_valid[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_update", 32'({bus.out_valid, busy, bus.in_ready, bus.out_chan,
                             bus.out_full, bus.out_data}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid[1] = 1'b1;
    bus.in_data[16 +: 16] = 16'd800;
    xact(0, 16'd8, 16'd1, 1'b0, 1'b0);
    xact(1, 16'd800, 16'd100, 1'b0, 1'b0);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
